// File: rtl/lc3b_types.sv
// lc3b_types: parameter-independent types and constants shared by the
// lc3b pipeline stages.
//   lc3b_nzp  : 3-bit condition code / branch mask, ordered {n,z,p}
//   CC_*      : one-hot condition-code encodings; CC_RESET is the value
//               the CC register takes out of reset (Z)
//   nzp_match : branch resolution of an IR mask against a CC value
package lc3b_types;

  typedef logic [2:0] lc3b_nzp;

  localparam lc3b_nzp CC_N     = 3'b100;
  localparam lc3b_nzp CC_Z     = 3'b010;
  localparam lc3b_nzp CC_P     = 3'b001;
  localparam lc3b_nzp CC_RESET = 3'b010;

  // A branch is taken when any condition selected by the mask is set.
  function automatic logic nzp_match(input lc3b_nzp mask, input lc3b_nzp cc);
    return |(mask & cc);
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: handshake, register-file write port and branch/CC signals
// of the writeback stage.
//   slave modport  : seen by wb_stage (inputs in_*/stall, outputs rf_*,
//                    cc_out, br_taken, in_ready)
//   master modport : seen by whatever drives the stage
// Optional macro WB_BYPASS_EN adds fwd_valid/fwd_dr/fwd_data.
interface wb_stage_if #(
  parameter int WIDTH = 16,
  parameter int NSRC  = 4,
  parameter int NREG  = 8
);
  import lc3b_types::*;

  localparam int DRW  = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int SELW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [NSRC*WIDTH-1:0] in_src;
  logic [SELW-1:0]       in_sel;
  logic [DRW-1:0]        in_dr;
  logic                  in_load_reg;
  logic                  in_load_cc;
  logic                  in_is_br;
  lc3b_nzp               in_nzp;
  logic                  stall;
  logic                  rf_we;
  logic [DRW-1:0]        rf_dr;
  logic [WIDTH-1:0]      rf_data;
  lc3b_nzp               cc_out;
  logic                  br_taken;
`ifdef WB_BYPASS_EN
  logic                  fwd_valid;
  logic [DRW-1:0]        fwd_dr;
  logic [WIDTH-1:0]      fwd_data;

  modport slave (
    input  in_valid, in_src, in_sel, in_dr, in_load_reg, in_load_cc,
           in_is_br, in_nzp, stall,
    output in_ready, rf_we, rf_dr, rf_data, cc_out, br_taken,
           fwd_valid, fwd_dr, fwd_data
  );

  modport master (
    output in_valid, in_src, in_sel, in_dr, in_load_reg, in_load_cc,
           in_is_br, in_nzp, stall,
    input  in_ready, rf_we, rf_dr, rf_data, cc_out, br_taken,
           fwd_valid, fwd_dr, fwd_data
  );
`else
  modport slave (
    input  in_valid, in_src, in_sel, in_dr, in_load_reg, in_load_cc,
           in_is_br, in_nzp, stall,
    output in_ready, rf_we, rf_dr, rf_data, cc_out, br_taken
  );

  modport master (
    output in_valid, in_src, in_sel, in_dr, in_load_reg, in_load_cc,
           in_is_br, in_nzp, stall,
    input  in_ready, rf_we, rf_dr, rf_data, cc_out, br_taken
  );
`endif

endinterface

// File: rtl/wb_gencc.sv
// wb_gencc: combinational value-to-NZP generator.
//   value_i : WIDTH-bit result being written back
//   nzp_o   : one-hot {n,z,p}; N on msb set, Z on zero, P otherwise
module wb_gencc
  import lc3b_types::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value_i,
  output lc3b_nzp          nzp_o
);

  // Priority keeps the result one-hot: the sign bit wins over zero test.
  always_comb begin
    nzp_o = CC_P;
    if (value_i[WIDTH-1]) begin
      nzp_o = CC_N;
    end else if (value_i == {WIDTH{1'b0}}) begin
      nzp_o = CC_Z;
    end else begin
      nzp_o = CC_P;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback/retire stage of the lc3b pipeline.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : valid/ready intake with NSRC packed sources and a
//                  select, downstream stall, register-file write port,
//                  NZP condition codes and branch-taken pulse.
// One instruction is held in the stage register; it retires (rf_we /
// br_taken pulse) on the first cycle it is valid and not stalled.
// Optional macro WB_BYPASS_EN exposes the held write (fwd_*) for decode
// forwarding before retire.
module wb_stage
  import lc3b_types::*;
#(
  parameter int WIDTH = 16,
  parameter int NSRC  = 4,
  parameter int NREG  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  wb_stage_if.slave   bus
);

  localparam int DRW  = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int SELW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [DRW-1:0]   dr_q, dr_d;
  logic             load_reg_q, load_reg_d;
  logic             br_q, br_d;
  lc3b_nzp          cc_q, cc_d;

  logic             accept;
  logic             retire;
  logic [WIDTH-1:0] sel_val;
  lc3b_nzp          sel_cc;

  // Source mux; a select beyond the last source falls back to source 0.
  always_comb begin
    sel_val = bus.in_src[WIDTH-1:0];
    for (int i = 0; i < NSRC; i++) begin
      if (bus.in_sel == SELW'(i)) begin
        sel_val = bus.in_src[i*WIDTH +: WIDTH];
      end else begin
        sel_val = sel_val;
      end
    end
  end

  wb_gencc #(.WIDTH(WIDTH)) u_gencc (
    .value_i (sel_val),
    .nzp_o   (sel_cc)
  );

  assign bus.in_ready = !valid_q || !bus.stall;
  assign accept       = bus.in_valid && bus.in_ready;
  assign retire       = valid_q && !bus.stall;

  // Next state: accept overwrites the entry (also covers retire+accept
  // with no bubble); the branch compares against cc_q before its update.
  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    dr_d       = dr_q;
    load_reg_d = load_reg_q;
    br_d       = br_q;
    cc_d       = cc_q;
    if (accept) begin
      valid_d    = 1'b1;
      data_d     = sel_val;
      dr_d       = bus.in_dr;
      load_reg_d = bus.in_load_reg;
      br_d       = bus.in_is_br && nzp_match(bus.in_nzp, cc_q);
      if (bus.in_load_cc) begin
        cc_d = sel_cc;
      end else begin
        cc_d = cc_q;
      end
    end else if (retire) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Stage and condition-code registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= 1'b0;
      data_q     <= {WIDTH{1'b0}};
      dr_q       <= {DRW{1'b0}};
      load_reg_q <= 1'b0;
      br_q       <= 1'b0;
      cc_q       <= CC_RESET;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      dr_q       <= dr_d;
      load_reg_q <= load_reg_d;
      br_q       <= br_d;
      cc_q       <= cc_d;
    end
  end

  // Retire pulses are gated by !stall so they fire once per instruction.
  assign bus.rf_we    = retire && load_reg_q;
  assign bus.rf_dr    = dr_q;
  assign bus.rf_data  = data_q;
  assign bus.br_taken = retire && br_q;
  assign bus.cc_out   = cc_q;

`ifdef WB_BYPASS_EN
  assign bus.fwd_valid = valid_q && load_reg_q;
  assign bus.fwd_dr    = dr_q;
  assign bus.fwd_data  = data_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage. DUT A uses the
// default NSRC=4; DUT B uses NSRC=3 to exercise an out-of-range select.
module tb_wb_stage;
  import lc3b_types::*;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  wb_stage_if #(.WIDTH(16), .NSRC(4), .NREG(8)) ia ();
  wb_stage_if #(.WIDTH(16), .NSRC(3), .NREG(8)) ib ();

  wb_stage #(.WIDTH(16), .NSRC(4), .NREG(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ia)
  );
  wb_stage #(.WIDTH(16), .NSRC(3), .NREG(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ib)
  );

  task automatic drive_a(input logic [15:0] s0, input logic [15:0] s1,
                         input logic [15:0] s2, input logic [15:0] s3,
                         input logic [1:0] sel, input logic [2:0] dr,
                         input logic lr, input logic lcc, input logic br,
                         input logic [2:0] nzp);
    ia.in_valid = 1'b1; ia.in_src = {s3, s2, s1, s0}; ia.in_sel = sel;
    ia.in_dr = dr; ia.in_load_reg = lr; ia.in_load_cc = lcc;
    ia.in_is_br = br; ia.in_nzp = nzp;
  endtask

  task automatic idle_a();
    ia.in_valid = 1'b0; ia.in_load_reg = 1'b0; ia.in_load_cc = 1'b0;
    ia.in_is_br = 1'b0; ia.in_nzp = 3'b000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    total_cnt++; if (ia.rf_we !== 1'b0) $display("FAIL reset_rf_we: got %b want 0", ia.rf_we); else pass_cnt++;
    total_cnt++; if (ia.br_taken !== 1'b0) $display("FAIL reset_br_taken: got %b want 0", ia.br_taken); else pass_cnt++;
    total_cnt++; if (ia.rf_data !== 16'h0000) $display("FAIL reset_rf_data: got %h want 0000", ia.rf_data); else pass_cnt++;
    total_cnt++; if (ia.cc_out !== 3'b010) $display("FAIL reset_cc: got %b want 010", ia.cc_out); else pass_cnt++;
    total_cnt++; if (ia.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", ia.in_ready); else pass_cnt++;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_write();
    drive_a(16'h0000, 16'h0000, 16'h0000, 16'h8001, 2'd3, 3'd5, 1'b1, 1'b1, 1'b0, 3'b000);
    tick();
    idle_a();
    total_cnt++; if (ia.rf_we !== 1'b1) $display("FAIL basic_rf_we: got %b want 1", ia.rf_we); else pass_cnt++;
    total_cnt++; if (ia.rf_dr !== 3'd5) $display("FAIL basic_rf_dr: got %0d want 5", ia.rf_dr); else pass_cnt++;
    total_cnt++; if (ia.rf_data !== 16'h8001) $display("FAIL basic_rf_data: got %h want 8001", ia.rf_data); else pass_cnt++;
    total_cnt++; if (ia.cc_out !== 3'b100) $display("FAIL basic_cc: got %b want 100", ia.cc_out); else pass_cnt++;
    total_cnt++; if (ia.br_taken !== 1'b0) $display("FAIL basic_br: got %b want 0", ia.br_taken); else pass_cnt++;
    tick();
    total_cnt++; if (ia.rf_we !== 1'b0) $display("FAIL basic_single_pulse: got %b want 0", ia.rf_we); else pass_cnt++;
  endtask

  task automatic test_stall();
    // A: mem source 1234 -> r2, no CC update; stall asserted from accept
    drive_a(16'h0000, 16'h1234, 16'h0000, 16'h0000, 2'd1, 3'd2, 1'b1, 1'b0, 1'b0, 3'b000);
    ia.stall = 1'b1;
    tick();
    // B offered during the stall: npc source 0042 -> r3 with CC update
    drive_a(16'h0000, 16'h0000, 16'h0042, 16'h0000, 2'd2, 3'd3, 1'b1, 1'b1, 1'b0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (ia.rf_we !== 1'b0) $display("FAIL stall_rf_we[%0d]: got %b want 0", i, ia.rf_we); else pass_cnt++;
      total_cnt++; if (ia.in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d]: got %b want 0", i, ia.in_ready); else pass_cnt++;
      total_cnt++; if (ia.rf_data !== 16'h1234) $display("FAIL stall_hold_data[%0d]: got %h want 1234", i, ia.rf_data); else pass_cnt++;
      total_cnt++; if (ia.cc_out !== 3'b100) $display("FAIL stall_hold_cc[%0d]: got %b want 100", i, ia.cc_out); else pass_cnt++;
      tick();
    end
    ia.stall = 1'b0;
    #1;
    total_cnt++; if (ia.rf_we !== 1'b1) $display("FAIL stall_release_we: got %b want 1", ia.rf_we); else pass_cnt++;
    total_cnt++; if (ia.rf_dr !== 3'd2) $display("FAIL stall_release_dr: got %0d want 2", ia.rf_dr); else pass_cnt++;
    total_cnt++; if (ia.in_ready !== 1'b1) $display("FAIL stall_release_ready: got %b want 1", ia.in_ready); else pass_cnt++;
    tick();
    idle_a();
    total_cnt++; if (ia.rf_we !== 1'b1) $display("FAIL stall_next_we: got %b want 1", ia.rf_we); else pass_cnt++;
    total_cnt++; if (ia.rf_dr !== 3'd3) $display("FAIL stall_next_dr: got %0d want 3", ia.rf_dr); else pass_cnt++;
    total_cnt++; if (ia.rf_data !== 16'h0042) $display("FAIL stall_next_data: got %h want 0042", ia.rf_data); else pass_cnt++;
    total_cnt++; if (ia.cc_out !== 3'b001) $display("FAIL stall_next_cc: got %b want 001", ia.cc_out); else pass_cnt++;
    tick();
    total_cnt++; if (ia.rf_we !== 1'b0) $display("FAIL stall_drained: got %b want 0", ia.rf_we); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    drive_a(16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'd3, 3'd1, 1'b1, 1'b1, 1'b0, 3'b000);
    tick();
    drive_a(16'h0010, 16'h0000, 16'h0000, 16'h0000, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'b010);
    total_cnt++; if (ia.rf_we !== 1'b1) $display("FAIL b2b_add_we: got %b want 1", ia.rf_we); else pass_cnt++;
    total_cnt++; if (ia.cc_out !== 3'b010) $display("FAIL b2b_add_cc: got %b want 010", ia.cc_out); else pass_cnt++;
    tick();
    drive_a(16'h0010, 16'h0000, 16'h0000, 16'h0000, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'b001);
    total_cnt++; if (ia.br_taken !== 1'b1) $display("FAIL b2b_brz: got %b want 1", ia.br_taken); else pass_cnt++;
    total_cnt++; if (ia.rf_we !== 1'b0) $display("FAIL b2b_br_no_we: got %b want 0", ia.rf_we); else pass_cnt++;
    tick();
    drive_a(16'h0010, 16'h0000, 16'h0000, 16'h0000, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'b000);
    total_cnt++; if (ia.br_taken !== 1'b0) $display("FAIL b2b_brp: got %b want 0", ia.br_taken); else pass_cnt++;
    tick();
    drive_a(16'h0010, 16'h0000, 16'h0000, 16'h0000, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'b111);
    total_cnt++; if (ia.br_taken !== 1'b0) $display("FAIL b2b_nzp000: got %b want 0", ia.br_taken); else pass_cnt++;
    tick();
    idle_a();
    total_cnt++; if (ia.br_taken !== 1'b1) $display("FAIL b2b_nzp111: got %b want 1", ia.br_taken); else pass_cnt++;
    tick();
    total_cnt++; if (ia.br_taken !== 1'b0) $display("FAIL b2b_drained: got %b want 0", ia.br_taken); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    drive_a(16'h0005, 16'h0000, 16'h0000, 16'h0000, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0, 3'b000);
    tick();
    drive_a(16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'd3, 3'd0, 1'b0, 1'b1, 1'b1, 3'b001);
    total_cnt++; if (ia.cc_out !== 3'b001) $display("FAIL simul_old_cc: got %b want 001", ia.cc_out); else pass_cnt++;
    tick();
    idle_a();
    total_cnt++; if (ia.br_taken !== 1'b1) $display("FAIL simul_br: got %b want 1", ia.br_taken); else pass_cnt++;
    total_cnt++; if (ia.cc_out !== 3'b010) $display("FAIL simul_new_cc: got %b want 010", ia.cc_out); else pass_cnt++;
    tick();
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    drive_a(16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 2'd0, 3'd4, 1'b1, 1'b0, 1'b0, 3'b000);
    ia.stall = 1'b1;
    tick();
    idle_a();
    total_cnt++; if (ia.fwd_valid !== 1'b1) $display("FAIL byp_valid: got %b want 1", ia.fwd_valid); else pass_cnt++;
    total_cnt++; if (ia.fwd_dr !== 3'd4) $display("FAIL byp_dr: got %0d want 4", ia.fwd_dr); else pass_cnt++;
    total_cnt++; if (ia.fwd_data !== 16'hBEEF) $display("FAIL byp_data: got %h want beef", ia.fwd_data); else pass_cnt++;
    total_cnt++; if (ia.rf_we !== 1'b0) $display("FAIL byp_no_we: got %b want 0", ia.rf_we); else pass_cnt++;
    ia.stall = 1'b0;
    tick();
    total_cnt++; if (ia.fwd_valid !== 1'b0) $display("FAIL byp_cleared: got %b want 0", ia.fwd_valid); else pass_cnt++;
  endtask
`endif

  task automatic test_out_of_range();
    ib.in_valid = 1'b1; ib.in_src = {16'h3333, 16'h2222, 16'h1111};
    ib.in_sel = 2'd3; ib.in_dr = 3'd7; ib.in_load_reg = 1'b1; ib.in_load_cc = 1'b1;
    tick();
    ib.in_sel = 2'd2;
    total_cnt++; if (ib.rf_data !== 16'h1111) $display("FAIL oor_data: got %h want 1111", ib.rf_data); else pass_cnt++;
    total_cnt++; if (ib.rf_we !== 1'b1) $display("FAIL oor_we: got %b want 1", ib.rf_we); else pass_cnt++;
    total_cnt++; if (ib.rf_dr !== 3'd7) $display("FAIL oor_dr: got %0d want 7", ib.rf_dr); else pass_cnt++;
    total_cnt++; if (ib.cc_out !== 3'b001) $display("FAIL oor_cc: got %b want 001", ib.cc_out); else pass_cnt++;
    tick();
    ib.in_valid = 1'b0;
    total_cnt++; if (ib.rf_data !== 16'h3333) $display("FAIL sel2_data: got %h want 3333", ib.rf_data); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_midstall();
    drive_a(16'h0000, 16'h0000, 16'h0000, 16'h8000, 2'd3, 3'd6, 1'b1, 1'b1, 1'b0, 3'b000);
    ia.stall = 1'b1;
    tick();
    idle_a();
    total_cnt++; if (ia.in_ready !== 1'b0) $display("FAIL rst_pre_ready: got %b want 0", ia.in_ready); else pass_cnt++;
    total_cnt++; if (ia.cc_out !== 3'b100) $display("FAIL rst_pre_cc: got %b want 100", ia.cc_out); else pass_cnt++;
    reset_n = 1'b0;
    #1;
    total_cnt++; if (ia.rf_we !== 1'b0) $display("FAIL rst_mid_we: got %b want 0", ia.rf_we); else pass_cnt++;
    total_cnt++; if (ia.cc_out !== 3'b010) $display("FAIL rst_mid_cc: got %b want 010", ia.cc_out); else pass_cnt++;
    total_cnt++; if (ia.in_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", ia.in_ready); else pass_cnt++;
    total_cnt++; if (ia.rf_data !== 16'h0000) $display("FAIL rst_mid_data: got %h want 0000", ia.rf_data); else pass_cnt++;
    ia.stall = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total_cnt++; if (ia.rf_we !== 1'b0) $display("FAIL rst_after_we[%0d]: got %b want 0", i, ia.rf_we); else pass_cnt++;
    end
  endtask

  initial begin
    ia.in_src = '0; ia.in_sel = '0; ia.in_dr = '0; ia.stall = 1'b0;
    idle_a();
    ib.in_valid = 1'b0; ib.in_src = '0; ib.in_sel = '0; ib.in_dr = '0;
    ib.in_load_reg = 1'b0; ib.in_load_cc = 1'b0; ib.in_is_br = 1'b0;
    ib.in_nzp = 3'b000; ib.stall = 1'b0;
    test_reset();
    test_basic_write();
    test_stall();
    test_back_to_back();
    test_simultaneous();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    test_out_of_range();
    test_reset_midstall();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
